// File: rtl/debug_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : debug_tx_fifo
// Purpose  : Byte FIFO between the debug sequence generator and the UART
//            transmit path. Absorbs the fast "DBG:" burst, hands bytes to the
//            UART through a valid/ready handshake and reports occupancy and
//            dropped pushes for the register bank.
// Ports    : clk          - system clock
//            resetb       - asynchronous active-low reset
//            wr_en        - push strobe (one entry per high cycle)
//            wr_data      - push data
//            tx_data      - head-of-queue byte, valid while tx_valid=1
//            tx_valid     - queue non-empty
//            tx_ready     - UART can accept a byte this cycle
//            level        - occupancy, 0..DEPTH
//            full / empty - level==DEPTH / level==0
//            overflow     - sticky flag: a push was dropped since last clear
//            drop_count   - saturating count of dropped pushes
//            clr_overflow - clears overflow and drop_count
// Revision : 1.0 - initial release
// ============================================================================
module debug_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_count_q, drop_count_d;

   logic              pop;
   logic              push;
   logic              drop;
   logic [PW-1:0]     occ;

   // Pointers carry one extra MSB, so their modular difference spans
   // 0..DEPTH and distinguishes full from empty.
   assign occ      = wr_ptr_q - rd_ptr_q;
   assign level    = occ;
   assign full     = (occ == PW'(DEPTH));
   assign empty    = (occ == '0);
   assign tx_valid = ~empty;
   assign tx_data  = mem_q[rd_ptr_q[AW-1:0]];

   assign pop  = tx_valid & tx_ready;
   // A pop in the same cycle frees the slot, so a push at full is accepted.
   assign push = wr_en & (~full | pop);
   assign drop = wr_en & full & ~pop;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      // A drop coinciding with a clear wins: the count restarts at one.
      if (drop) begin
         overflow_d = 1'b1;
         if (clr_overflow)
            drop_count_d = DROP_W'(1);
         else if (~&drop_count_q)
            drop_count_d = drop_count_q + DROP_W'(1);
      end else if (clr_overflow) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Storage is cleared on reset so tx_data reads as zero afterwards.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_tx_fifo
// Purpose  : Self-checking bench for debug_tx_fifo. A queue holds the bytes
//            the bench expects to leave the FIFO; every accepted pop is
//            compared against the queue head. Flags and counters are compared
//            against a small reference model after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_tx_fifo;

   localparam int DEPTH  = 16;
   localparam int WIDTH  = 8;
   localparam int DROP_W = 8;

   logic                   clk;
   logic                   resetb;
   logic                   wr_en;
   logic [WIDTH-1:0]       wr_data;
   logic [WIDTH-1:0]       tx_data;
   logic                   tx_valid;
   logic                   tx_ready;
   logic [$clog2(DEPTH):0] level;
   logic                   full;
   logic                   empty;
   logic                   overflow;
   logic [DROP_W-1:0]      drop_count;
   logic                   clr_overflow;

   debug_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .level        (level),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] sb[$];   // expected output order
   int               m_dc;    // model drop count
   logic             m_ov;    // model overflow flag

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("level",      32'(level),      32'(sb.size()));
      chk("full",       32'(full),       32'(sb.size() == DEPTH));
      chk("empty",      32'(empty),      32'(sb.size() == 0));
      chk("overflow",   32'(overflow),   32'(m_ov));
      chk("drop_count", 32'(drop_count), 32'(m_dc));
   endtask

   // One clock: drive inputs, check handshake outputs before the edge,
   // advance the model, then check registered state after the edge.
   task automatic cycle(input logic wr, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
      logic m_pop, m_push, m_drop, m_full;
      logic [WIDTH-1:0] exp_byte;
      wr_en        = wr;
      wr_data      = d;
      tx_ready     = rdy;
      clr_overflow = clr;
      #1;
      chk("tx_valid", 32'(tx_valid), 32'(sb.size() != 0));
      m_full = (sb.size() == DEPTH);
      m_pop  = (sb.size() != 0) && rdy;
      m_push = wr && (!m_full || m_pop);
      m_drop = wr && m_full && !m_pop;
      if (m_pop) begin
         exp_byte = sb.pop_front();
         chk("tx_data", 32'(tx_data), 32'(exp_byte));
      end
      if (m_push) sb.push_back(d);
      if (m_drop) begin
         m_ov = 1'b1;
         if (clr)            m_dc = 1;
         else if (m_dc < 255) m_dc = m_dc + 1;
      end else if (clr) begin
         m_ov = 1'b0;
         m_dc = 0;
      end
      @(posedge clk);
      #1;
      chk_state();
   endtask

   initial begin
      resetb       = 1'b0;
      wr_en        = 1'b0;
      wr_data      = '0;
      tx_ready     = 1'b0;
      clr_overflow = 1'b0;
      m_ov         = 1'b0;
      m_dc         = 0;
      #3;
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk_state();
      @(posedge clk);
      #2 resetb = 1'b1;
      @(posedge clk);
      #1;
      chk_state();

      // Basic order: four pushes held, then drained one per cycle.
      cycle(1'b1, 8'h44, 1'b0, 1'b0);
      cycle(1'b1, 8'h42, 1'b0, 1'b0);
      cycle(1'b1, 8'h47, 1'b0, 1'b0);
      cycle(1'b1, 8'h3A, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Overflow: 19 pushes into a 16-deep queue, then drain.
      for (int i = 0; i < 19; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("ovf_drops", 32'(drop_count), 32'd3);
      for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("full_pp_level", 32'(level), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Wrap-around: push/pop pairs with tx_ready toggling each cycle.
      for (int i = 0; i < 80; i++)
         cycle(i % 2 == 0, 8'(8'h80 + i / 2), i % 2 == 1, 1'b0);
      // Sustained streaming with a few entries queued.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Saturation: fill then force 300 drops.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("sat_drops", 32'(drop_count), 32'd255);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_drops", 32'(drop_count), 32'd0);

      // Clear coinciding with a drop: drop wins.
      cycle(1'b1, 8'hEF, 1'b0, 1'b1);
      chk("coll_ovf", 32'(overflow), 32'd1);
      chk("coll_drops", 32'(drop_count), 32'd1);

      // Asynchronous reset with five entries queued.
      for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_level", 32'(level), 32'd5);
      #2 resetb = 1'b0;
      #1;
      sb.delete();
      m_ov = 1'b0;
      m_dc = 0;
      chk("arst_tx_valid", 32'(tx_valid), 32'd0);
      chk("arst_tx_data", 32'(tx_data), 32'h0);
      chk_state();
      @(posedge clk);
      #2 resetb = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
